cp0_reg: RTL

//  Coprocessor-0 register file: the consumer of the writeback-stage CP0 write (we/addr/data) and the source of mfc0 reads.

---
 rtl/cp0_reg_pkg.sv | 58 +++++
 rtl/cp0_reg_if.sv | 36 +++
 rtl/cp0_reg_timer.sv | 51 +++++
 rtl/cp0_reg.sv | 106 ++++++++++
 4 files changed

// File: rtl/cp0_reg_pkg.sv
// Shared CP0 definitions: register numbers, exception type codes, ExcCode values,
// Status/Cause bit positions and the exception-type decoder.
package cp0_reg_pkg;

    localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_REG_EPC     = 5'd14;
    localparam logic [4:0] CP0_REG_PRID    = 5'd15;
    localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

    localparam logic [31:0] EXC_TYPE_INT     = 32'h1;
    localparam logic [31:0] EXC_TYPE_SYSCALL = 32'h8;
    localparam logic [31:0] EXC_TYPE_BREAK   = 32'h9;
    localparam logic [31:0] EXC_TYPE_RI      = 32'ha;
    localparam logic [31:0] EXC_TYPE_OV      = 32'hc;
    localparam logic [31:0] EXC_TYPE_TRAP    = 32'hd;
    localparam logic [31:0] EXC_TYPE_ERET    = 32'he;

    localparam logic [4:0] EXCCODE_INT     = 5'd0;
    localparam logic [4:0] EXCCODE_SYSCALL = 5'd8;
    localparam logic [4:0] EXCCODE_BREAK   = 5'd9;
    localparam logic [4:0] EXCCODE_RI      = 5'd10;
    localparam logic [4:0] EXCCODE_OV      = 5'd12;
    localparam logic [4:0] EXCCODE_TRAP    = 5'd13;

    localparam int STATUS_EXL_BIT = 1;
    localparam int CAUSE_BD_BIT   = 31;
    localparam int CAUSE_IP_HI    = 15;
    localparam int CAUSE_IP_LO    = 10;

    // Software-writable Cause bits: IV, WP, IP1:0
    localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

    typedef struct packed {
        logic       valid;
        logic       eret;
        logic [4:0] code;
    } exc_dec_t;

    function automatic exc_dec_t decode_exc(input logic [31:0] etype);
        exc_dec_t d;
        d = '0;
        case (etype)
            EXC_TYPE_INT:     begin d.valid = 1'b1; d.code = EXCCODE_INT;     end
            EXC_TYPE_SYSCALL: begin d.valid = 1'b1; d.code = EXCCODE_SYSCALL; end
            EXC_TYPE_BREAK:   begin d.valid = 1'b1; d.code = EXCCODE_BREAK;   end
            EXC_TYPE_RI:      begin d.valid = 1'b1; d.code = EXCCODE_RI;      end
            EXC_TYPE_OV:      begin d.valid = 1'b1; d.code = EXCCODE_OV;      end
            EXC_TYPE_TRAP:    begin d.valid = 1'b1; d.code = EXCCODE_TRAP;    end
            EXC_TYPE_ERET:    begin d.valid = 1'b1; d.eret = 1'b1;            end
            default:          d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cp0_reg_if.sv
// Pipeline <-> CP0 bus: writeback write port, mfc0 read port, MEM exception inputs
// and register contents. master = pipeline side, slave = cp0_reg.
interface cp0_reg_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] data_i;
    logic [4:0]  raddr_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;

    logic [31:0] data_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] config_o;
    logic [31:0] prid_o;
    logic        timer_int_o;

    modport master (
        output we_i, waddr_i, data_i, raddr_i, int_i,
               excepttype_i, current_inst_addr_i, is_in_delayslot_i,
        input  data_o, count_o, compare_o, status_o, cause_o,
               epc_o, config_o, prid_o, timer_int_o
    );

    modport slave (
        input  we_i, waddr_i, data_i, raddr_i, int_i,
               excepttype_i, current_inst_addr_i, is_in_delayslot_i,
        output data_o, count_o, compare_o, status_o, cause_o,
               epc_o, config_o, prid_o, timer_int_o
    );
endinterface

// File: rtl/cp0_reg_timer.sv
// Count/Compare timer: free-running Count, Compare match raises a sticky timer
// interrupt that only a Compare write clears.
module cp0_timer
    import cp0_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        timer_int_q, timer_int_d;

    always_comb begin
        count_d     = count_q + 32'd1;
        compare_d   = compare_q;
        timer_int_d = timer_int_q;
        if (compare_q != 32'd0 && count_q == compare_q)
            timer_int_d = 1'b1;
        if (we_i && waddr_i == CP0_REG_COUNT)
            count_d = data_i;
        // Compare write acknowledges the interrupt, even against a same-cycle match
        if (we_i && waddr_i == CP0_REG_COMPARE) begin
            compare_d   = data_i;
            timer_int_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            compare_q   <= '0;
            timer_int_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            compare_q   <= compare_d;
            timer_int_q <= timer_int_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_reg.sv
// CP0 register file: Status/Cause/EPC, read-only Config/PrId, exception capture,
// mfc0 read mux. Count/Compare timer is present only when CP0_TIMER_EN is defined.
module cp0_reg
    import cp0_reg_pkg::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h0048_0102,
    parameter logic [31:0] CONFIG_VAL = 32'h0000_8000,
    parameter logic [31:0] STATUS_RST = 32'h1000_0000
) (
    input  logic       clk,
    input  logic       rst,
    cp0_reg_if.slave   bus
);

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] count_w, compare_w;
    logic        timer_int_w;
    exc_dec_t    exc;

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk         (clk),
        .rst         (rst),
        .we_i        (bus.we_i),
        .waddr_i     (bus.waddr_i),
        .data_i      (bus.data_i),
        .count_o     (count_w),
        .compare_o   (compare_w),
        .timer_int_o (timer_int_w)
    );
`else
    assign count_w     = '0;
    assign compare_w   = '0;
    assign timer_int_w = 1'b0;
`endif

    assign exc = decode_exc(bus.excepttype_i);

    always_comb begin
        status_d = status_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        cause_d[CAUSE_IP_HI:CAUSE_IP_LO] = bus.int_i;

        if (bus.we_i) begin
            case (bus.waddr_i)
                CP0_REG_STATUS: status_d = bus.data_i;
                CP0_REG_CAUSE:  cause_d  = (cause_d & ~CAUSE_WMASK) | (bus.data_i & CAUSE_WMASK);
                CP0_REG_EPC:    epc_d    = bus.data_i;
                default: ;
            endcase
        end

        // Exception applied after mtc0 so its fields override a same-cycle write
        if (exc.valid) begin
            if (exc.eret) begin
                status_d[STATUS_EXL_BIT] = 1'b0;
            end else begin
                if (!status_q[STATUS_EXL_BIT]) begin
                    epc_d = bus.is_in_delayslot_i ? bus.current_inst_addr_i - 32'd4
                                                  : bus.current_inst_addr_i;
                    cause_d[CAUSE_BD_BIT] = bus.is_in_delayslot_i;
                end
                status_d[STATUS_EXL_BIT] = 1'b1;
                cause_d[6:2] = exc.code;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= STATUS_RST;
            cause_q  <= '0;
            epc_q    <= '0;
        end else begin
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
        end
    end

    always_comb begin
        case (bus.raddr_i)
            CP0_REG_COUNT:   bus.data_o = count_w;
            CP0_REG_COMPARE: bus.data_o = compare_w;
            CP0_REG_STATUS:  bus.data_o = status_q;
            CP0_REG_CAUSE:   bus.data_o = cause_q;
            CP0_REG_EPC:     bus.data_o = epc_q;
            CP0_REG_PRID:    bus.data_o = PRID_VAL;
            CP0_REG_CONFIG:  bus.data_o = CONFIG_VAL;
            default:         bus.data_o = '0;
        endcase
    end

    assign bus.count_o     = count_w;
    assign bus.compare_o   = compare_w;
    assign bus.timer_int_o = timer_int_w;
    assign bus.status_o    = status_q;
    assign bus.cause_o     = cause_q;
    assign bus.epc_o       = epc_q;
    assign bus.config_o    = CONFIG_VAL;
    assign bus.prid_o      = PRID_VAL;

endmodule
